sync_fifo_ctrl: RTL and testbench

- Single-clock, parametrised FIFO: storage array plus full control logic (pointers, occupancy count, status flags, error flags).
- Successor to the dual-port FIFO memory primitive.
- Adds registered read data, programmable almost-full/almost-empty thresholds, a live occupancy count and sticky overflow/underflow detection.
- Sits between same-clock producer/consumer stages, e.g. UART/APB datapath buffering.

---
 rtl/sync_fifo_ctrl_if.sv | 31 +++
 rtl/sync_fifo_ctrl.sv | 121 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for sync_fifo_ctrl: write side, read side,
// occupancy and status/error flags.
interface sync_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  wfull;
  logic                  rempty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output winc, wdata, rinc,
    input  rdata, rvalid, wfull, rempty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, rvalid, wfull, rempty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads (0-cycle latency).
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ZERO  = '0;
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = (ADDR_WIDTH)'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_r;
  logic [ADDR_WIDTH-1:0] rptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  wfull_r;
  logic                  rempty_r;
  logic                  af_r;
  logic                  ae_r;
  logic                  rvalid_r;
  logic                  ovf_r;
  logic                  unf_r;

  // Accept decode and next occupancy; a read at full frees the slot the write uses.
  always_comb begin
    empty_s = (count_r == CNT_ZERO);
    full_s  = (count_r == CNT_DEPTH);
    rd_ok_s = bus.rinc && !empty_s;
    wr_ok_s = bus.winc && (!full_s || rd_ok_s);
    if (wr_ok_s && !rd_ok_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (rd_ok_s && !wr_ok_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage array; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok_s) begin
      mem_r[wptr_r] <= bus.wdata;
    end
  end

  // Pointers, occupancy, flags (registered from next count) and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      count_r  <= CNT_ZERO;
      wfull_r  <= 1'b0;
      rempty_r <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      if (wr_ok_s) wptr_r <= wptr_r + PTR_ONE;
      if (rd_ok_s) rptr_r <= rptr_r + PTR_ONE;
      count_r  <= count_nxt_s;
      wfull_r  <= (count_nxt_s == CNT_DEPTH);
      rempty_r <= (count_nxt_s == CNT_ZERO);
      af_r     <= (count_nxt_s >= CNT_AF);
      ae_r     <= (count_nxt_s <= CNT_AE);
      if (bus.winc && full_s && !rd_ok_s) ovf_r <= 1'b1;
      if (bus.rinc && empty_s) unf_r <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; valid whenever something is stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= (count_nxt_s != CNT_ZERO);
    end
  end

  assign bus.rdata = mem_r[rptr_r];
`else
  logic [DATA_WIDTH-1:0] rdata_r;

  // Registered read port; rdata holds its value when no word is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= rd_ok_s;
      if (rd_ok_s) rdata_r <= mem_r[rptr_r];
    end
  end

  assign bus.rdata = rdata_r;
`endif

  assign bus.rvalid       = rvalid_r;
  assign bus.wfull        = wfull_r;
  assign bus.rempty       = rempty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.count        = count_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed, table-driven bench for sync_fifo_ctrl (DEPTH 8, AF 6, AE 2).
module tb_sync_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    int         cnt;
    logic       rv;
    logic [7:0] rd;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic w, input logic [7:0] wd, input logic ri,
                     input int c, input logic rv, input logic [7:0] rd,
                     input logic o, input logic u);
    vec_t v;
    v.rst = r; v.winc = w; v.wdata = wd; v.rinc = ri;
    v.cnt = c; v.rv = rv; v.rd = rd; v.ovf = o; v.unf = u;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] wd, input logic ri);
    rst = r; bus.winc = w; bus.wdata = wd; bus.rinc = ri;
    @(posedge clk);
    #1;
  endtask

  // Status flags expected from an occupancy value.
  task automatic chk_count(input string tag, input int c);
    chk({tag, " count"}, 32'(bus.count), 32'(c));
    chk({tag, " flags"}, {28'd0, bus.rempty, bus.wfull, bus.almost_full, bus.almost_empty},
        {28'd0, 1'(c == 0), 1'(c == 8), 1'(c >= 6), 1'(c <= 2)});
  endtask

  initial begin
    bus.winc = 1'b0; bus.wdata = 8'h00; bus.rinc = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    add(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, i + 1, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'hFF, 1'b0, 8, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 8'h00, 1'b1, 7 - i, 1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h17, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 8'(8'h01 + i), 1'b0, i + 1, 1'b0, 8'h17, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 8'h00, 1'b1, 4 - i, 1'b1, 8'(8'h01 + i), 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'hA0, 1'b1, 1, 1'b0, 8'h05, 1'b1, 1'b1);
    for (int i = 1; i < 6; i++) add(1'b0, 1'b1, 8'(8'hA0 + i), 1'b1, 1, 1'b1, 8'(8'hA0 + i - 1), 1'b1, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 8'hA5, 1'b1, 1'b1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, i + 1, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h99, 1'b1, 8, 1'b1, 8'h30, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 8'h00, 1'b1, 7 - i, 1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, i + 1, 1'b0, 8'h99, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h55, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1);

    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      step(vecs[k].rst, vecs[k].winc, vecs[k].wdata, vecs[k].rinc);
      chk_count(tag, vecs[k].cnt);
      chk({tag, " rvalid"}, 32'(bus.rvalid), 32'(vecs[k].rv));
      chk({tag, " rdata"}, 32'(bus.rdata), 32'(vecs[k].rd));
      chk({tag, " overflow"}, 32'(bus.overflow), 32'(vecs[k].ovf));
      chk({tag, " underflow"}, 32'(bus.underflow), 32'(vecs[k].unf));
    end

    // Stored word waits across idle cycles, then appears exactly one cycle after rinc.
    step(1'b0, 1'b1, 8'h66, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("idle rvalid", 32'(bus.rvalid), 32'd0);
    chk_count("idle", 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pop rvalid", 32'(bus.rvalid), 32'd1);
    chk("pop rdata", 32'(bus.rdata), 32'h66);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("after pop rvalid", 32'(bus.rvalid), 32'd0);
    chk("after pop rdata hold", 32'(bus.rdata), 32'h66);
    chk_count("after pop", 0);
`else
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("fwft reset rvalid", 32'(bus.rvalid), 32'd0);
    chk_count("fwft reset", 0);
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    chk("fwft head rdata", 32'(bus.rdata), 32'h5A);
    chk("fwft head rvalid", 32'(bus.rvalid), 32'd1);
    step(1'b0, 1'b1, 8'h5B, 1'b0);
    chk("fwft hold rdata", 32'(bus.rdata), 32'h5A);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("fwft next rdata", 32'(bus.rdata), 32'h5B);
    chk_count("fwft next", 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("fwft empty rvalid", 32'(bus.rvalid), 32'd0);
    chk_count("fwft empty", 0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("fwft underflow", 32'(bus.underflow), 32'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
